// File: rtl/wb_arbiter_rr_b3_pkg.sv
// Shared types for the Wishbone B3 round-robin arbiter: bus widths, FSM state
// encoding and the watchdog counter sizing helper.
package wb_arb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    // Bits needed to hold the value 'limit' itself.
    function automatic int cnt_width(input int unsigned limit);
        return $clog2(limit + 32'd1);
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_b3_if.sv
// Wishbone B3 classic bus bundle; the master modport drives the request side,
// the slave modport drives the response side.
interface wishbone_b3;
    import wb_arb_pkg::*;

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_m2s;
    logic [DAT_W-1:0] dat_s2m;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             ack;
    logic             err;
    logic             rty;

    modport master (
        output adr, dat_m2s, sel, we, cyc, stb, cti, bte,
        input  dat_s2m, ack, err, rty
    );

    modport slave (
        input  adr, dat_m2s, sel, we, cyc, stb, cti, bte,
        output dat_s2m, ack, err, rty
    );

endinterface

// File: rtl/wb_arbiter_rr_b3_rr_select.sv
// Combinational round-robin pick: first set request at index >= ptr_i,
// wrapping to index 0; returns one-hot pick, its index and a valid flag.
module wb_arb_rr_select #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    logic          hi_found_s;
    logic [N-1:0]  hi_pick_s;
    logic [PW-1:0] hi_idx_s;
    logic          lo_found_s;
    logic [N-1:0]  lo_pick_s;
    logic [PW-1:0] lo_idx_s;

    // Two priority scans: at/above the pointer first, then the wrapped part below it.
    always_comb begin
        hi_found_s = 1'b0;
        hi_pick_s  = '0;
        hi_idx_s   = '0;
        lo_found_s = 1'b0;
        lo_pick_s  = '0;
        lo_idx_s   = '0;
        for (int j = 0; j < N; j++) begin
            if (req_i[j] && (j >= int'(ptr_i)) && !hi_found_s) begin
                hi_found_s   = 1'b1;
                hi_pick_s[j] = 1'b1;
                hi_idx_s     = PW'(j);
            end else if (req_i[j] && (j < int'(ptr_i)) && !lo_found_s) begin
                lo_found_s   = 1'b1;
                lo_pick_s[j] = 1'b1;
                lo_idx_s     = PW'(j);
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        if (hi_found_s) begin
            pick_o = hi_pick_s;
            idx_o  = hi_idx_s;
        end else begin
            pick_o = lo_pick_s;
            idx_o  = lo_idx_s;
        end
        valid_o = hi_found_s | lo_found_s;
    end

endmodule

// File: rtl/wb_arbiter_rr_b3.sv
// Round-robin, non-preemptive Wishbone B3 arbiter with combinational bus mux.
// Define WB_ARB_TIMEOUT_EN to build in the stalled-slave watchdog (ERR state).
module wb_arbiter_rr_b3
    import wb_arb_pkg::*;
#(
    parameter int MASTERS        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    wishbone_b3.slave         master [MASTERS],
    wishbone_b3.master        slave,
    output logic [MASTERS-1:0] grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int PTR_W = $clog2(MASTERS);

    arb_state_e         state_q;
    logic [MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic               busy_q;

    logic [MASTERS-1:0] req_s;
    logic [MASTERS-1:0] pick_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_valid_s;
    logic [PTR_W-1:0]   ptr_d;
    logic               route_s;
    logic               err_s;

    logic [ADR_W-1:0] m_adr_s [MASTERS];
    logic [DAT_W-1:0] m_dat_s [MASTERS];
    logic [SEL_W-1:0] m_sel_s [MASTERS];
    logic [2:0]       m_cti_s [MASTERS];
    logic [1:0]       m_bte_s [MASTERS];
    logic [MASTERS-1:0] m_we_s;
    logic [MASTERS-1:0] m_stb_s;

    logic [ADR_W-1:0] s_adr_s;
    logic [DAT_W-1:0] s_dat_s;
    logic [SEL_W-1:0] s_sel_s;
    logic [2:0]       s_cti_s;
    logic [1:0]       s_bte_s;
    logic             s_we_s;
    logic             s_stb_s;
    logic             s_cyc_s;

    assign route_s = (state_q == BUSY);
    assign err_s   = (state_q == ERR);

    for (genvar i = 0; i < MASTERS; i++) begin : g_master
        assign req_s[i]   = master[i].cyc;
        assign m_adr_s[i] = master[i].adr;
        assign m_dat_s[i] = master[i].dat_m2s;
        assign m_sel_s[i] = master[i].sel;
        assign m_cti_s[i] = master[i].cti;
        assign m_bte_s[i] = master[i].bte;
        assign m_we_s[i]  = master[i].we;
        assign m_stb_s[i] = master[i].stb;

        assign master[i].dat_s2m = (grant_q[i] && route_s) ? slave.dat_s2m : '0;
        assign master[i].ack     = grant_q[i] & route_s & slave.ack;
        assign master[i].rty     = grant_q[i] & route_s & slave.rty;
        assign master[i].err     = grant_q[i] & ((route_s & slave.err) | err_s);
    end

    // AND-OR mux of the granted master onto the shared bus; zero when nothing is granted.
    always_comb begin
        s_adr_s = '0;
        s_dat_s = '0;
        s_sel_s = '0;
        s_cti_s = '0;
        s_bte_s = '0;
        for (int i = 0; i < MASTERS; i++) begin
            s_adr_s = s_adr_s | (m_adr_s[i] & {ADR_W{grant_q[i]}});
            s_dat_s = s_dat_s | (m_dat_s[i] & {DAT_W{grant_q[i]}});
            s_sel_s = s_sel_s | (m_sel_s[i] & {SEL_W{grant_q[i]}});
            s_cti_s = s_cti_s | (m_cti_s[i] & {3{grant_q[i]}});
            s_bte_s = s_bte_s | (m_bte_s[i] & {2{grant_q[i]}});
        end
        s_we_s  = |(m_we_s & grant_q);
        s_stb_s = |(m_stb_s & grant_q);
        s_cyc_s = |(req_s & grant_q);
    end

    assign slave.adr     = s_adr_s;
    assign slave.dat_m2s = s_dat_s;
    assign slave.sel     = s_sel_s;
    assign slave.cti     = s_cti_s;
    assign slave.bte     = s_bte_s;
    assign slave.we      = s_we_s;
    assign slave.cyc     = s_cyc_s & ~err_s;
    assign slave.stb     = s_stb_s & ~err_s;

    wb_arb_rr_select #(
        .N  (MASTERS),
        .PW (PTR_W)
    ) u_select (
        .req_i   (req_s),
        .ptr_i   (rr_ptr_q),
        .pick_o  (pick_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign ptr_d = (pick_idx_s == PTR_W'(MASTERS - 1)) ? '0 : pick_idx_s + PTR_W'(1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stall_s;
    logic             timeout_q;

    assign stall_s   = route_s & s_stb_s & ~slave.ack & ~slave.err & ~slave.rty;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Arbitration FSM; a released (or never held) grant always re-arbitrates at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else if (!s_cyc_s) begin
            if (pick_valid_s) begin
                state_q  <= BUSY;
                grant_q  <= pick_s;
                rr_ptr_q <= ptr_d;
                busy_q   <= 1'b1;
            end else begin
                state_q  <= IDLE;
                grant_q  <= '0;
                busy_q   <= 1'b0;
            end
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            busy_q <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            if (route_s && stall_s && (cnt_d == CNT_W'(TIMEOUT_CYCLES))) begin
                state_q   <= ERR;
                cnt_q     <= '0;
                timeout_q <= 1'b1;
            end else if (route_s && stall_s) begin
                state_q   <= BUSY;
                cnt_q     <= cnt_d;
                timeout_q <= 1'b0;
            end else begin
                state_q   <= BUSY;
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end
`else
            state_q <= BUSY;
`endif
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: doc/wb_arbiter_rr_b3.md
WB_ARBITER_RR_B3 -- requirements
Module: wb_arbiter_rr_b3

Interface
REQ-001 SHALL have parameter MASTERS, default 3, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, stalled-cycle limit before a bus error is forced (1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port master  wishbone_b3.slave  array[MASTERS]  requester buses.
REQ-006 SHALL have port slave  wishbone_b3.master  1  shared downstream bus.
REQ-007 SHALL have port grant_o  output  MASTERS  one-hot registered grant; all zero when idle.
REQ-008 SHALL have port busy_o  output  1  high while any grant is held.
REQ-009 SHALL have port timeout_o  output  1  one-cycle pulse when a forced error is issued.

Function
REQ-010 SHALL implement states IDLE, BUSY, ERR (ERR exists only per REQ-024).
REQ-011 In IDLE, slave outputs SHALL be zero and every master's dat_s2m/ack/err/rty SHALL be zero.
REQ-012 IDLE->BUSY SHALL occur on the first edge with any master[i].cyc high: 1-cycle arbitration latency.
REQ-013 Selection SHALL be round-robin: the first requester at index >= rr_ptr, wrapping modulo MASTERS.
REQ-014 On every new grant, rr_ptr SHALL become (granted index + 1) mod MASTERS.
REQ-015 In BUSY, the granted master's adr/cyc/dat_m2s/sel/we/stb/cti/bte SHALL drive slave combinationally (zero added latency); slave's dat_s2m/ack/err/rty SHALL route only to the granted master; others SHALL see zero.
REQ-016 The grant SHALL be held while the granted master's cyc stays high, regardless of other requests (no preemption).
REQ-017 When the granted cyc falls, the slave cyc SHALL fall the same cycle; at the next edge the block SHALL re-arbitrate directly (BUSY->BUSY, new grant) if any cyc is high, else go to IDLE.
REQ-018 Simultaneous requests SHALL resolve solely per REQ-013; a request rising in the same cycle as a release SHALL be eligible for that re-arbitration.
REQ-019 busy_o SHALL equal |grant_o.

Reset
REQ-020 On rst_n low, state SHALL be IDLE immediately, grant_o=0, busy_o=0, timeout_o=0, rr_ptr=0, timeout counter=0, irrespective of in-flight cycles.
REQ-021 After rst_n rises, the first grant SHALL go to the lowest-indexed requester.
REQ-022 A master holding cyc across reset SHALL be re-arbitrated like a new request.

Configuration
REQ-023 Macro WB_ARB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-024 With WB_ARB_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle with granted cyc&stb high and slave ack/err/rty all low, clear otherwise; on reaching TIMEOUT_CYCLES, the next state SHALL be ERR for exactly one cycle, in which slave cyc/stb are forced low, the granted master sees err=1, ack=rty=0, and timeout_o=1; ERR then returns to BUSY with the same grant and a cleared counter (or, if that master's cyc is low, re-arbitrates per REQ-017).
REQ-025 Without WB_ARB_TIMEOUT_EN: no counter, no ERR state, timeout_o tied to 0.

Structure
REQ-026 Package wb_arb_pkg SHALL hold the state enum (IDLE, BUSY, ERR) and the counter-width function ceil(log2(TIMEOUT_CYCLES+1)).
REQ-027 Sub-module wb_arb_rr_select SHALL implement combinational round-robin selection (req vector, rr_ptr -> one-hot pick, valid); all state stays in wb_arbiter_rr_b3.
REQ-028 Per-master muxing SHALL use generate loops over MASTERS, with no hard-coded master count.

Verification
REQ-029 Single master: m1 cyc=stb=1, adr=0x100 at cycle 0 -> grant_o=3'b010 at cycle 1, slave.adr=0x100; slave ack routed to m1 only; m1 cyc low -> IDLE next edge.
REQ-030 Round-robin: m0, m1, m2 all requesting continuously with 2-cycle transactions -> grant order 0,1,2,0 and no idle cycle between grants.
REQ-031 No preemption: m2 granted and m0 raises cyc -> grant_o stays 3'b100 until m2 cyc falls, then becomes 3'b001.
REQ-032 Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): m0 stb held with no ack -> ERR after 4 stalled cycles, m0 err=1 and timeout_o=1 for one cycle, slave.stb=0 that cycle.
REQ-033 Reset mid-cycle: rst_n low while m1 is granted -> grant_o=0 and slave.cyc=0 without a clock edge; after release with m1 and m2 requesting, m1 is granted first (rr_ptr=0).
REQ-034 Build without WB_ARB_TIMEOUT_EN: stalled slave for 1000 cycles -> grant held, timeout_o=0 throughout.
